// File: rtl/clkdiv_pkg.sv
// rtl/clkdiv_pkg.sv - shared types for the multi-channel clock-enable generator
//
// Purpose: channel state encoding used by clkdiv_ch and visible to benches.
// Ports:   none (package).
package clkdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } clkdiv_st_t;

endpackage

// File: rtl/clkdiv_ch.sv
// rtl/clkdiv_ch.sv - one clock-enable channel: ratio, phase, burst, square wave
//
// Purpose: divides clk by (div+1) into a one-cycle cke pulse and a 50% square
//          wave, starting from counter value phs, optionally stopping after
//          bst ticks.
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset
//   ena  in   channel enable (level); low forces IDLE on the next edge
//   trg  in   restart strobe, honoured only while ena is high
//   div  in   [DWC] division ratio - 1, used live every cycle
//   phs  in   [DWC] counter start value, sampled at start/restart
//   bst  in   [DWB] ticks per burst, 0 = continuous, sampled at start/restart
//   cke  out  registered tick pulse
//   sqr  out  registered square wave, toggles with each cke
//   bsy  out  registered (state == RUN)
module clkdiv_ch
  import clkdiv_pkg::*;
#(
  parameter int DWC = 16,
  parameter int DWB = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic           trg,
  input  logic [DWC-1:0] div,
  input  logic [DWC-1:0] phs,
  input  logic [DWB-1:0] bst,
  output logic           cke,
  output logic           sqr,
  output logic           bsy
);

  clkdiv_st_t     st_q,  st_d;
  logic [DWC-1:0] cnt_q, cnt_d;
  logic [DWB-1:0] tcn_q, tcn_d;
  logic [DWB-1:0] bst_q, bst_d;
  logic           cke_q, cke_d;
  logic           sqr_q, sqr_d;
  logic           bsy_q, bsy_d;

  logic tick;
  logic load;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    tcn_d = tcn_q;
    bst_d = bst_q;
    cke_d = 1'b0;
    sqr_d = sqr_q;
    load  = 1'b0;
    // >= rather than == so that lowering div below the current count wraps
    // immediately instead of running on to the counter's natural overflow.
    tick  = (cnt_q >= div);

    if (!ena) begin
      st_d  = IDLE;
      cnt_d = '0;
      tcn_d = '0;
      sqr_d = 1'b0;
    end else if (trg) begin
      // Restart beats a coincident tick, so no cke is produced this cycle.
      load = 1'b1;
    end else begin
      case (st_q)
        IDLE: load = 1'b1;
        RUN: begin
          if (tick) begin
            cke_d = 1'b1;
            sqr_d = ~sqr_q;
            cnt_d = '0;
            if (bst_q != '0) begin
              // Last tick of the burst still emits cke before parking in DONE.
              if (tcn_q == bst_q - 1'b1) begin
                st_d = DONE;
              end
              tcn_d = tcn_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (load) begin
      st_d  = RUN;
      cnt_d = phs;
      tcn_d = '0;
      bst_d = bst;
      sqr_d = 1'b0;
    end

    bsy_d = (st_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= IDLE;
      cnt_q <= '0;
      tcn_q <= '0;
      bst_q <= '0;
      cke_q <= 1'b0;
      sqr_q <= 1'b0;
      bsy_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      tcn_q <= tcn_d;
      bst_q <= bst_d;
      cke_q <= cke_d;
      sqr_q <= sqr_d;
      bsy_q <= bsy_d;
    end
  end

  assign cke = cke_q;
  assign sqr = sqr_q;
  assign bsy = bsy_q;

endmodule

// File: rtl/clkdiv_mc.sv
// rtl/clkdiv_mc.sv - multi-channel clock-enable generator top
//
// Purpose: CHN independent clkdiv_ch channels sharing one restart strobe, so
//          channels restarted together stay phase-locked.
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset
//   ena  in   [CHN] per-channel enable
//   trg  in   global restart strobe
//   div  in   [CHN][DWC] per-channel ratio - 1
//   phs  in   [CHN][DWC] per-channel start counter value
//   bst  in   [CHN][DWB] per-channel burst length, 0 = continuous
//   cke  out  [CHN] clock-enable pulses
//   sqr  out  [CHN] square waves
//   bsy  out  [CHN] channel running
module clkdiv_mc
  import clkdiv_pkg::*;
#(
  parameter int CHN = 4,
  parameter int DWC = 16,
  parameter int DWB = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHN-1:0]           ena,
  input  logic                     trg,
  input  logic [CHN-1:0][DWC-1:0]  div,
  input  logic [CHN-1:0][DWC-1:0]  phs,
  input  logic [CHN-1:0][DWB-1:0]  bst,
  output logic [CHN-1:0]           cke,
  output logic [CHN-1:0]           sqr,
  output logic [CHN-1:0]           bsy
);

  for (genvar i = 0; i < CHN; i++) begin : g_ch
    clkdiv_ch #(
      .DWC(DWC),
      .DWB(DWB)
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .ena(ena[i]),
      .trg(trg),
      .div(div[i]),
      .phs(phs[i]),
      .bst(bst[i]),
      .cke(cke[i]),
      .sqr(sqr[i]),
      .bsy(bsy[i])
    );
  end

endmodule

// File: tb/tb_clkdiv_mc.sv
// tb/tb_clkdiv_mc.sv - scoreboard bench for clkdiv_mc
module tb_clkdiv_mc;

  localparam int CHN = 4;
  localparam int DWC = 16;
  localparam int DWB = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [CHN-1:0]          ena;
  logic                    trg;
  logic [CHN-1:0][DWC-1:0] div;
  logic [CHN-1:0][DWC-1:0] phs;
  logic [CHN-1:0][DWB-1:0] bst;
  logic [CHN-1:0]          cke;
  logic [CHN-1:0]          sqr;
  logic [CHN-1:0]          bsy;

  clkdiv_mc #(.CHN(CHN), .DWC(DWC), .DWB(DWB)) dut (
    .clk(clk), .rst(rst), .ena(ena), .trg(trg),
    .div(div), .phs(phs), .bst(bst),
    .cke(cke), .sqr(sqr), .bsy(bsy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CHN-1:0] cke;
    logic [CHN-1:0] sqr;
    logic [CHN-1:0] bsy;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: each channel is "active" once started, "finished" once
  // its burst has delivered the requested number of ticks. pos is the phase
  // position inside the current period; a tick happens whenever it has
  // reached the (live) ratio.
  bit m_act [CHN];
  bit m_fin [CHN];
  bit m_ck  [CHN];
  bit m_sq  [CHN];
  int m_pos [CHN];
  int m_ticks [CHN];
  int m_burst [CHN];

  function automatic obs_t model_edge();
    obs_t o;
    for (int c = 0; c < CHN; c++) begin
      if (rst || !ena[c]) begin
        m_act[c] = 0; m_fin[c] = 0; m_ck[c] = 0; m_sq[c] = 0;
        m_pos[c] = 0; m_ticks[c] = 0;
      end else if (trg || !m_act[c]) begin
        m_act[c] = 1; m_fin[c] = 0; m_ck[c] = 0; m_sq[c] = 0;
        m_pos[c] = int'(phs[c]); m_ticks[c] = 0; m_burst[c] = int'(bst[c]);
      end else if (m_fin[c]) begin
        m_ck[c] = 0;
      end else if (m_pos[c] >= int'(div[c])) begin
        m_ck[c] = 1;
        m_sq[c] = !m_sq[c];
        m_pos[c] = 0;
        m_ticks[c]++;
        if (m_burst[c] != 0 && m_ticks[c] == m_burst[c]) m_fin[c] = 1;
      end else begin
        m_ck[c] = 0;
        m_pos[c]++;
      end
      o.cke[c] = m_ck[c];
      o.sqr[c] = m_sq[c];
      o.bsy[c] = m_act[c] && !m_fin[c];
    end
    return o;
  endfunction

  // One clock: predict the outcome of the coming edge from the inputs now
  // applied, queue it, then advance past the edge.
  task automatic step();
    exp_q.push_back(model_edge());
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({cke, sqr, bsy} !== e) begin
          n_errors++;
          $display("FAIL outputs t=%0t actual cke=%b sqr=%b bsy=%b required cke=%b sqr=%b bsy=%b",
                   $time, cke, sqr, bsy, e.cke, e.sqr, e.bsy);
        end
      end
    end
  end

  initial begin : stim
    int found;

    // Reset held with all channels enabled: outputs must stay low.
    rst = 1'b1; ena = '1; trg = 1'b0;
    div = '0; phs = '0; bst = '0;
    for (int c = 0; c < CHN; c++) div[c] = DWC'(c + 2);
    run(4);
    rst = 1'b0;
    run(12);

    // ch0 divide by 4, ch1 div=0 (cke held high).
    ena = '0; run(1);
    div[0] = 16'd3; phs[0] = '0; bst[0] = '0;
    div[1] = 16'd0; phs[1] = '0; bst[1] = '0;
    ena = 4'b0011;
    run(40);

    // Burst of 3 at ratio 10, then a trg for a second burst.
    ena = '0; run(1);
    div[0] = 16'd9; phs[0] = '0; bst[0] = 8'd3;
    ena = 4'b0001;
    run(45);
    trg = 1'b1; run(1); trg = 1'b0;
    run(40);

    // Two channels with a phase offset of 4, restarted together.
    div[0] = 16'd7; phs[0] = 16'd0; bst[0] = '0;
    div[1] = 16'd7; phs[1] = 16'd4; bst[1] = '0;
    ena = 4'b0011; run(3);
    trg = 1'b1; run(1); trg = 1'b0;
    run(800);

    // Lower div below the running count.
    ena = '0; run(1);
    div[0] = 16'd200; phs[0] = '0; bst[0] = '0;
    ena = 4'b0001;
    run(152);
    div[0] = 16'd50;
    run(160);

    // trg landing on a tick cycle.
    ena = '0; run(1);
    div[0] = 16'd4; phs[0] = 16'd2; bst[0] = '0;
    ena = 4'b0001; run(1);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (m_act[0] && !m_fin[0] && m_pos[0] >= int'(div[0])) found = 1;
      else step();
    end
    n_checks++;
    if (found == 0) begin
      n_errors++;
      $display("FAIL tick_align actual no tick within 20 cycles required tick");
    end
    trg = 1'b1; run(1); trg = 1'b0;
    run(12);

    // ena dropped mid-burst; phs > div start.
    div[0] = 16'd3; phs[0] = 16'd9; bst[0] = 8'd5;
    trg = 1'b1; run(1); trg = 1'b0;
    run(8);
    ena = '0; run(3);

    // Randomized traffic on all channels.
    ena = '1;
    for (int c = 0; c < CHN; c++) begin
      div[c] = DWC'($urandom_range(0, 12));
      phs[c] = DWC'($urandom_range(0, 20));
      bst[c] = DWB'($urandom_range(0, 4));
    end
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 999) < 4);
      trg = ($urandom_range(0, 99) < 2);
      for (int c = 0; c < CHN; c++) begin
        if ($urandom_range(0, 99) < 2) ena[c] = ~ena[c];
        if ($urandom_range(0, 99) < 3) div[c] = DWC'($urandom_range(0, 12));
        if ($urandom_range(0, 99) < 5) phs[c] = DWC'($urandom_range(0, 20));
        if ($urandom_range(0, 99) < 5) bst[c] = DWB'($urandom_range(0, 4));
      end
      step();
    end
    rst = 1'b0; trg = 1'b0;

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain actual %0d pending required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
